job_timer_fsm: RTL and testbench

//   Parametrised job-timer controller: on go, runs a counter up to a programmable

---
 rtl/job_timer_fsm.sv | 117 +++++++++++
 tb/tb_job_timer_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/job_timer_fsm.sv
// Job timer: counts from 0 up to a per-job latched terminal count, then pulses done.
// Supports kill (abort), pause/resume, and optional back-to-back auto restart.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   go       in   start request (IDLE, or FINISH when AUTO_RESTART=1)
//   kill     in   abort request, level sensitive
//   pause    in   freeze counter while running, level sensitive
//   tc       in   terminal count, latched when go is accepted
//   done     out  one-cycle pulse in FINISH
//   aborted  out  high in every ABORT cycle
//   busy     out  high in ACTIVE or PAUSED
//   count    out  current counter value
//   state    out  IDLE=0 ACTIVE=1 PAUSED=2 FINISH=3 ABORT=4
module job_timer_fsm #(
    parameter int unsigned CNT_W        = 8,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             kill,
    input  logic             pause,
    input  logic [CNT_W-1:0] tc,
    output logic             done,
    output logic             aborted,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_PAUSED = 3'd2,
        S_FINISH = 3'd3,
        S_ABORT  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] tc_q,    tc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ACTIVE;
                    count_d = '0;
                    tc_d    = tc;
                end
            end
            S_ACTIVE: begin
                // Terminal compare beats pause so a job never
                // parks in PAUSED with its work already complete.
                if (kill) begin
                    state_d = S_ABORT;
                end else if (count_q == tc_q) begin
                    state_d = S_FINISH;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_PAUSED: begin
                if (kill) begin
                    state_d = S_ABORT;
                end else if (!pause) begin
                    state_d = S_ACTIVE;
                end
            end
            S_FINISH: begin
                count_d = '0;
                if (AUTO_RESTART && go) begin
                    state_d = S_ACTIVE;
                    tc_d    = tc;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                count_d = '0;
                if (!kill) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign done    = (state_q == S_FINISH);
    assign aborted = (state_q == S_ABORT);
    assign busy    = (state_q == S_ACTIVE) || (state_q == S_PAUSED);
    assign count   = count_q;
    assign state   = state_q;

endmodule

// File: tb/tb_job_timer_fsm.sv
// Scoreboard bench for job_timer_fsm: two instances (AUTO_RESTART 0 and 1)
// share stimulus and are checked against a job-level reference model.
module tb_job_timer_fsm;

    logic       clk;
    logic       reset_n;
    logic       go;
    logic       kill;
    logic       pause;
    logic [7:0] tc;

    logic       done0, aborted0, busy0;
    logic [7:0] count0;
    logic [2:0] state0;
    logic       done1, aborted1, busy1;
    logic [7:0] count1;
    logic [2:0] state1;

    job_timer_fsm #(.CNT_W(8), .AUTO_RESTART(1'b0)) u_ar0 (
        .clk(clk), .reset_n(reset_n), .go(go), .kill(kill),
        .pause(pause), .tc(tc), .done(done0), .aborted(aborted0),
        .busy(busy0), .count(count0), .state(state0)
    );

    job_timer_fsm #(.CNT_W(8), .AUTO_RESTART(1'b1)) u_ar1 (
        .clk(clk), .reset_n(reset_n), .go(go), .kill(kill),
        .pause(pause), .tc(tc), .done(done1), .aborted(aborted1),
        .busy(busy1), .count(count1), .state(state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] cnt;
        logic       d;
        logic       a;
        logic       b;
    } obs_t;

    // Reference model phases, named rather than encoded.
    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_DONE, M_KILLED} phase_e;

    typedef struct {
        phase_e ph;
        int     cnt;
        int     limit;
    } mdl_t;

    obs_t obs0, obs1;
    assign obs0 = {state0, count0, done0, aborted0, busy0};
    assign obs1 = {state1, count1, done1, aborted1, busy1};

    obs_t q0[$];
    obs_t q1[$];
    mdl_t m0, m1;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t expect_of(mdl_t m);
        obs_t o;
        int   code;
        case (m.ph)
            M_IDLE:   code = 0;
            M_RUN:    code = 1;
            M_HOLD:   code = 2;
            M_DONE:   code = 3;
            default:  code = 4;
        endcase
        o.st  = 3'(code);
        o.cnt = 8'(m.cnt);
        o.d   = (m.ph == M_DONE);
        o.a   = (m.ph == M_KILLED);
        o.b   = (m.ph == M_RUN) || (m.ph == M_HOLD);
        return o;
    endfunction

    // One clock of job behaviour, written from the job rules.
    function automatic mdl_t advance(mdl_t m, bit ar, bit g, bit k,
                                     bit p, int t);
        mdl_t n = m;
        if (m.ph == M_IDLE) begin
            if (g) begin n.ph = M_RUN; n.cnt = 0; n.limit = t; end
        end else if (m.ph == M_DONE) begin
            n.cnt = 0;
            if (ar && g) begin n.ph = M_RUN; n.limit = t; end
            else n.ph = M_IDLE;
        end else if (m.ph == M_KILLED) begin
            n.cnt = 0;
            if (!k) n.ph = M_IDLE;
        end else if (k) begin
            n.ph = M_KILLED;
        end else if (m.ph == M_HOLD) begin
            if (!p) n.ph = M_RUN;
        end else if (m.cnt >= m.limit) begin
            n.ph = M_DONE;
        end else if (p) begin
            n.ph = M_HOLD;
        end else begin
            n.cnt = m.cnt + 1;
        end
        return n;
    endfunction

    task automatic chk(string nm, obs_t act, obs_t want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got st=%0d cnt=%0d d=%0b a=%0b b=%0b want st=%0d cnt=%0d d=%0b a=%0b b=%0b",
                     nm, $time, act.st, act.cnt, act.d, act.a, act.b,
                     want.st, want.cnt, want.d, want.a, want.b);
        end
    endtask

    task automatic mdl_reset();
        m0.ph = M_IDLE; m0.cnt = 0; m0.limit = 0;
        m1 = m0;
    endtask

    task automatic cyc(bit g, bit k, bit p, int t);
        @(negedge clk);
        go    = g;
        kill  = k;
        pause = p;
        tc    = 8'(t);
        m0 = advance(m0, 1'b0, g, k, p, t);
        m1 = advance(m1, 1'b1, g, k, p, t);
        q0.push_back(expect_of(m0));
        q1.push_back(expect_of(m1));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, $urandom_range(0, 255));
    endtask

    task automatic run_until(int c);
        int g = 0;
        while (!(m0.ph == M_RUN && m0.cnt == c) && g < 1000) begin
            cyc(0, 0, 0, $urandom_range(0, 255));
            g++;
        end
    endtask

    // Async reset asserted mid low-phase; outputs must clear before any edge.
    task automatic async_reset();
        @(negedge clk);
        go = 0; kill = 0; pause = 0;
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_ar0", obs0, '0);
        chk("async_rst_ar1", obs1, '0);
        mdl_reset();
        @(negedge clk);
        chk("hold_rst_ar0", obs0, '0);
        chk("hold_rst_ar1", obs1, '0);
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) chk("sb_ar0", obs0, q0.pop_front());
            if (q1.size() > 0) chk("sb_ar1", obs1, q1.pop_front());
        end
    end

    initial begin : driver
        reset_n = 1'b0;
        go = 0; kill = 0; pause = 0; tc = '0;
        mdl_reset();
        #12;
        chk("reset_ar0", obs0, '0);
        chk("reset_ar1", obs1, '0);
        @(negedge clk);
        reset_n = 1'b1;

        // long job, tc changing afterwards must not matter
        cyc(1, 0, 0, 100);
        idle(110);

        // boundary terminal counts
        cyc(1, 0, 0, 0);
        idle(4);
        cyc(1, 0, 0, 255);
        idle(262);

        // kill at count 7 for three cycles
        cyc(1, 0, 0, 20);
        run_until(7);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 20);
        idle(5);

        // pause at count 5 for four cycles
        cyc(1, 0, 0, 20);
        run_until(5);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 20);
        idle(25);

        // pause then pause+kill
        cyc(1, 0, 0, 20);
        run_until(3);
        cyc(0, 0, 1, 20);
        cyc(0, 0, 1, 20);
        cyc(0, 1, 1, 20);
        idle(4);

        // go held high, tc=3: back-to-back jobs
        for (int i = 0; i < 24; i++) cyc(1, 0, 0, 3);
        idle(6);

        // async reset at count 50, then a normal job
        cyc(1, 0, 0, 100);
        run_until(50);
        async_reset();
        cyc(1, 0, 0, 10);
        idle(15);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int t;
            t = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                              : $urandom_range(0, 12);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 5) == 0, t);
            if ($urandom_range(0, 999) == 0) async_reset();
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
